hoaa_sub_serial: RTL and testbench

HOAA_SUB_SERIAL -- requirements
Module: hoaa_sub_serial

---
 rtl/hoaa_sub_serial.sv | 112 +++++++++++
 tb/tb_hoaa_sub_serial.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/hoaa_sub_serial.sv
// Bit-serial a-b (a + ~b + 1), LSB first, with an approximate OR-based LSB stage.
// Define HOAA_EXACT_LSB_EN to make bit 0 an exact full adder (exact subtraction).
module hoaa_sub_serial #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out
);

  localparam int unsigned IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_d;
  logic [WIDTH-1:0] a_q, b_q, a_d, b_d, diff_d;
  logic [IW-1:0]    idx, idx_d;
  logic             carry, carry_d;
  logic             in_ready_d, out_valid_d, borrow_d;
  logic             a_bit, nb_bit, s_bit, c_bit, last;

  // One adder stage on the selected bit; bit 0 carries the +1 of the negation.
  always_comb begin
    a_bit  = a_q[idx];
    nb_bit = ~b_q[idx];
    s_bit  = a_bit ^ nb_bit ^ carry;
    c_bit  = (a_bit & nb_bit) | (carry & (a_bit ^ nb_bit));
    if (idx == '0) begin
`ifdef HOAA_EXACT_LSB_EN
      s_bit = ~(a_bit ^ nb_bit);
      c_bit = a_bit | nb_bit;
`else
      // (a0|1) collapses: sum = 1^~b0, carry = ~b0
      s_bit = ~nb_bit;
      c_bit = nb_bit;
`endif
    end
  end

  assign last = (idx == IW'(WIDTH - 1));

  // Next-state and next-output logic
  always_comb begin
    state_d  = state;
    a_d      = a_q;
    b_d      = b_q;
    idx_d    = idx;
    carry_d  = carry;
    diff_d   = diff;
    borrow_d = borrow_out;
    case (state)
      IDLE: begin
        if (in_ready && in_valid) begin
          a_d     = a;
          b_d     = b;
          idx_d   = '0;
          carry_d = 1'b0;
          state_d = RUN;
        end
      end
      RUN: begin
        diff_d[idx] = s_bit;
        carry_d     = c_bit;
        idx_d       = idx + IW'(1);
        if (last) begin
          borrow_d = ~c_bit;
          idx_d    = '0;
          state_d  = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    in_ready_d  = (state_d == IDLE);
    out_valid_d = (state_d == DONE);
  end

  // State and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      a_q        <= '0;
      b_q        <= '0;
      idx        <= '0;
      carry      <= 1'b0;
      diff       <= '0;
      borrow_out <= 1'b0;
      in_ready   <= 1'b0;
      out_valid  <= 1'b0;
    end else begin
      state      <= state_d;
      a_q        <= a_d;
      b_q        <= b_d;
      idx        <= idx_d;
      carry      <= carry_d;
      diff       <= diff_d;
      borrow_out <= borrow_d;
      in_ready   <= in_ready_d;
      out_valid  <= out_valid_d;
    end
  end

endmodule

// File: tb/tb_hoaa_sub_serial.sv
// Directed bench for hoaa_sub_serial (WIDTH=8); expectations follow HOAA_EXACT_LSB_EN.
module tb_hoaa_sub_serial;

  localparam int unsigned W = 8;

  logic         clk, rst_n, in_valid, in_ready, out_valid, out_ready, borrow_out;
  logic [W-1:0] a, b, diff;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] d_apx;
    logic       bo_apx;
    logic [7:0] d_ex;
    logic       bo_ex;
  } vec_t;

  vec_t vecs[8];
  int   checks;
  int   errors;

  hoaa_sub_serial #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .diff(diff), .borrow_out(borrow_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] exp_d(input vec_t v);
`ifdef HOAA_EXACT_LSB_EN
    return v.d_ex;
`else
    return v.d_apx;
`endif
  endfunction

  function automatic logic exp_bo(input vec_t v);
`ifdef HOAA_EXACT_LSB_EN
    return v.bo_ex;
`else
    return v.bo_apx;
`endif
  endfunction

  // Issue one operand pair, measure latency, compare result in the first DONE cycle
  task automatic run_op(input logic [7:0] va, input logic [7:0] vb,
                        input logic [7:0] ed, input logic eb, input logic pulse);
    int n;
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("ready_before_op", 32'(in_ready), 32'd1);
    a = va;
    b = vb;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    n = 1;
    while (!out_valid && n < 40) begin
      if (pulse && n == 3) begin
        in_valid = 1'b1;
        a = 8'hAA;
        b = 8'h55;
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
      n++;
    end
    in_valid = 1'b0;
    check("latency", 32'(n), 32'(W + 1));
    check("diff", 32'(diff), 32'(ed));
    check("borrow_out", 32'(borrow_out), 32'(eb));
  endtask

  initial begin
    int k, cyc, last_cyc;
    checks = 0;
    errors = 0;
    clk = 1'b0;
    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    a = '0;
    b = '0;

    //                a      b     apx d  bo    ex d   bo
    vecs[0] = '{8'h05, 8'h03, 8'h01, 1'b0, 8'h02, 1'b0};
    vecs[1] = '{8'h10, 8'h10, 8'h00, 1'b0, 8'h00, 1'b0};
    vecs[2] = '{8'h00, 8'h01, 8'hFF, 1'b1, 8'hFF, 1'b1};
    vecs[3] = '{8'hFF, 8'h00, 8'hFE, 1'b0, 8'hFF, 1'b0};
    vecs[4] = '{8'h07, 8'h02, 8'h04, 1'b0, 8'h05, 1'b0};
    vecs[5] = '{8'h80, 8'h7F, 8'h01, 1'b0, 8'h01, 1'b0};
    vecs[6] = '{8'h01, 8'h02, 8'hFE, 1'b1, 8'hFF, 1'b1};
    vecs[7] = '{8'h3C, 8'hA5, 8'h97, 1'b1, 8'h97, 1'b1};

    // Reset state
    #1;
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_diff", 32'(diff), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("ready_before_edge", 32'(in_ready), 32'd0);
    @(posedge clk);
    #1;
    check("ready_after_edge", 32'(in_ready), 32'd1);
    @(negedge clk);

    // Table-driven vectors
    for (int i = 0; i < 8; i++) begin
      run_op(vecs[i].a, vecs[i].b, exp_d(vecs[i]), exp_bo(vecs[i]), 1'b0);
      @(negedge clk);
      check("retired", 32'(out_valid), 32'd0);
    end

    // Backpressure in DONE: result held stable
    out_ready = 1'b0;
    run_op(vecs[0].a, vecs[0].b, exp_d(vecs[0]), exp_bo(vecs[0]), 1'b0);
    repeat (5) begin
      @(negedge clk);
      check("hold_valid", 32'(out_valid), 32'd1);
      check("hold_diff", 32'(diff), 32'(exp_d(vecs[0])));
    end
    out_ready = 1'b1;
    @(negedge clk);
    check("hold_release", 32'(out_valid), 32'd0);

    // in_valid pulsed mid-RUN is ignored
    run_op(vecs[3].a, vecs[3].b, exp_d(vecs[3]), exp_bo(vecs[3]), 1'b1);
    @(negedge clk);

    // Reset while processing bit 4
    while (!in_ready) @(negedge clk);
    a = 8'hFF;
    b = 8'h00;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_in_ready", 32'(in_ready), 32'd0);
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_diff", 32'(diff), 32'd0);
    check("midrst_borrow", 32'(borrow_out), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("midrst_ready_back", 32'(in_ready), 32'd1);
    run_op(vecs[4].a, vecs[4].b, exp_d(vecs[4]), exp_bo(vecs[4]), 1'b0);
    @(negedge clk);

    // Back-to-back with both handshakes held high
    k = 0;
    cyc = 0;
    last_cyc = 0;
    a = vecs[0].a;
    b = vecs[0].b;
    in_valid = 1'b1;
    while (k < 4 && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (out_valid) begin
        check("b2b_diff", 32'(diff), 32'(exp_d(vecs[k])));
        check("b2b_borrow", 32'(borrow_out), 32'(exp_bo(vecs[k])));
        if (k > 0) check("b2b_spacing", 32'(cyc - last_cyc), 32'(W + 2));
        last_cyc = cyc;
        k++;
        if (k < 4) begin
          a = vecs[k].a;
          b = vecs[k].b;
        end else begin
          in_valid = 1'b0;
        end
      end
    end
    in_valid = 1'b0;
    check("b2b_count", 32'(k), 32'd4);
    repeat (W + 4) @(negedge clk);
    check("b2b_no_extra", 32'(out_valid), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
